// File: rtl/pipeline_ctrl_pkg.sv
// rtl/pipeline_ctrl_pkg.sv - shared run-control state encodings and address-width default
// Contents: state_t (ST_RUN, ST_DRAIN, ST_HALTED, ST_STEP), NB_REG_ADDR_DEFAULT.
// The debug unit uses the same encodings to decode o_state.
package pipeline_ctrl_pkg;

  localparam int NB_REG_ADDR_DEFAULT = 5;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2,
    ST_STEP   = 2'd3
  } state_t;

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// rtl/pipeline_ctrl_hazard_detect.sv - combinational load-use and branch-flush detection
// Ports:
//   i_id_rs1, i_id_rs2 : source registers of the instruction in ID
//   i_ex_rd            : destination register of the instruction in EX
//   i_ex_mem_read      : EX instruction is a load
//   i_branch_taken     : branch/jump resolved taken in ID
//   o_lu               : load-use hazard
//   o_bf               : branch flush (suppressed by a load-use stall)
module pipeline_ctrl_hazard_detect #(
  parameter int NB_REG_ADDR = 5
) (
  input  logic [NB_REG_ADDR-1:0] i_id_rs1,
  input  logic [NB_REG_ADDR-1:0] i_id_rs2,
  input  logic [NB_REG_ADDR-1:0] i_ex_rd,
  input  logic                   i_ex_mem_read,
  input  logic                   i_branch_taken,
  output logic                   o_lu,
  output logic                   o_bf
);

  // x0 is never a real producer, so a load targeting it cannot create a hazard.
  assign o_lu = i_ex_mem_read && (i_ex_rd != '0) &&
                ((i_ex_rd == i_id_rs1) || (i_ex_rd == i_id_rs2));

  // A stalled branch resolved on stale operands; let it re-resolve next cycle.
  assign o_bf = i_branch_taken && !o_lu;

endmodule

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - hazard and debug run-control unit for the 5-stage core
// Ports:
//   clk, i_rst (sync, active-high)
//   i_id_rs1, i_id_rs2, i_ex_rd, i_ex_mem_read, i_branch_taken : hazard inputs
//   i_halt_req (level), i_step_req (pulse), i_resume (pulse)   : debug control
//   o_pc_en, o_if_id_en, o_if_id_flush, o_id_ex_flush, o_pipe_en : pipeline control
//   o_halted, o_state                                            : run-control status
//   o_stall_cnt, o_flush_cnt : saturating event counters (only with PIPELINE_CTRL_PERF_EN)
// Optional macro: PIPELINE_CTRL_PERF_EN
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int NB_REG_ADDR  = NB_REG_ADDR_DEFAULT,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   i_rst,
  input  logic [NB_REG_ADDR-1:0] i_id_rs1,
  input  logic [NB_REG_ADDR-1:0] i_id_rs2,
  input  logic [NB_REG_ADDR-1:0] i_ex_rd,
  input  logic                   i_ex_mem_read,
  input  logic                   i_branch_taken,
  input  logic                   i_halt_req,
  input  logic                   i_step_req,
  input  logic                   i_resume,
  output logic                   o_pc_en,
  output logic                   o_if_id_en,
  output logic                   o_if_id_flush,
  output logic                   o_id_ex_flush,
  output logic                   o_pipe_en,
  output logic                   o_halted,
`ifdef PIPELINE_CTRL_PERF_EN
  output logic [31:0]            o_stall_cnt,
  output logic [31:0]            o_flush_cnt,
`endif
  output logic [1:0]             o_state
);

  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

  state_t     state, state_n;
  logic [3:0] cnt, cnt_n;
  logic       lu, bf;

  pipeline_ctrl_hazard_detect #(
    .NB_REG_ADDR (NB_REG_ADDR)
  ) u_hazard_detect (
    .i_id_rs1       (i_id_rs1),
    .i_id_rs2       (i_id_rs2),
    .i_ex_rd        (i_ex_rd),
    .i_ex_mem_read  (i_ex_mem_read),
    .i_branch_taken (i_branch_taken),
    .o_lu           (lu),
    .o_bf           (bf)
  );

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state <= ST_RUN;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n       = state;
    cnt_n         = cnt;
    o_pc_en       = 1'b0;
    o_if_id_en    = 1'b0;
    o_if_id_flush = 1'b0;
    o_id_ex_flush = 1'b0;
    o_pipe_en     = 1'b0;
    o_halted      = 1'b0;
    case (state)
      ST_RUN, ST_STEP: begin
        o_pipe_en     = 1'b1;
        o_pc_en       = !lu;
        o_if_id_en    = !lu;
        o_id_ex_flush = lu;
        o_if_id_flush = bf;
        if (state == ST_STEP) begin
          state_n = ST_HALTED;
        end else if (i_halt_req) begin
          state_n = ST_DRAIN;
          cnt_n   = DRAIN_LOAD;
        end
      end
      ST_DRAIN: begin
        // Fetch keeps tracking a taken target so resume restarts at the right PC,
        // while IF/ID is flushed to inject bubbles behind the last real instruction.
        o_pipe_en = 1'b1;
        o_pc_en   = bf;
        if (lu) begin
          // Hold IF/ID and the counter so the stalled ID instruction still retires.
          o_id_ex_flush = 1'b1;
        end else begin
          o_if_id_en    = 1'b1;
          o_if_id_flush = 1'b1;
          if (cnt == 4'd0) begin
            state_n = ST_HALTED;
          end else begin
            cnt_n = cnt - 4'd1;
          end
        end
      end
      ST_HALTED: begin
        o_halted = 1'b1;
        if (i_resume) begin
          state_n = ST_RUN;
        end else if (i_step_req) begin
          state_n = ST_STEP;
        end
      end
      default: begin
        state_n = ST_RUN;
      end
    endcase
    if (i_rst) begin
      o_pc_en       = 1'b0;
      o_if_id_en    = 1'b0;
      o_if_id_flush = 1'b0;
      o_id_ex_flush = 1'b0;
      o_pipe_en     = 1'b0;
      o_halted      = 1'b0;
    end
  end

  assign o_state = i_rst ? 2'd0 : state;

`ifdef PIPELINE_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (i_rst) begin
      o_stall_cnt <= '0;
      o_flush_cnt <= '0;
    end else begin
      if (lu && (state == ST_RUN || state == ST_STEP) && o_stall_cnt != '1) begin
        o_stall_cnt <= o_stall_cnt + 32'd1;
      end
      if (bf && o_flush_cnt != '1) begin
        o_flush_cnt <= o_flush_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - self-checking bench for pipeline_ctrl
module tb_pipeline_ctrl;

  localparam int NB  = 5;
  localparam int DRN = 4;

  // Reference-model modes, numbered as the o_state encoding.
  localparam int M_RUN = 0, M_DRAIN = 1, M_HALT = 2, M_STEP = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [NB-1:0] rs1, rs2, rd;
  logic          mr, br, halt, stp, res;
  logic          pc_en, if_id_en, if_id_flush, id_ex_flush, pipe_en, halted;
  logic [1:0]    state;
`ifdef PIPELINE_CTRL_PERF_EN
  logic [31:0]   stall_cnt, flush_cnt;
  longint        m_stall, m_flush;
`endif

  always #5 clk = ~clk;

  pipeline_ctrl #(.NB_REG_ADDR(NB), .DRAIN_CYCLES(DRN)) dut (
    .clk            (clk),
    .i_rst          (rst),
    .i_id_rs1       (rs1),
    .i_id_rs2       (rs2),
    .i_ex_rd        (rd),
    .i_ex_mem_read  (mr),
    .i_branch_taken (br),
    .i_halt_req     (halt),
    .i_step_req     (stp),
    .i_resume       (res),
    .o_pc_en        (pc_en),
    .o_if_id_en     (if_id_en),
    .o_if_id_flush  (if_id_flush),
    .o_id_ex_flush  (id_ex_flush),
    .o_pipe_en      (pipe_en),
    .o_halted       (halted),
`ifdef PIPELINE_CTRL_PERF_EN
    .o_stall_cnt    (stall_cnt),
    .o_flush_cnt    (flush_cnt),
`endif
    .o_state        (state)
  );

  int n_vec = 0;
  int n_err = 0;

  // Output vector layout: {pc_en, if_id_en, if_id_flush, id_ex_flush, pipe_en, halted, state[1:0]}
  logic [7:0] act_v;

  int m_mode       = M_RUN;
  int m_drain_left = 0;   // non-stalled bubble cycles still owed before halting

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic hz(input logic [NB-1:0] a1, a2, d, input logic m);
    return m && (d != 0) && (d == a1 || d == a2);
  endfunction

  function automatic logic [7:0] model_out(input logic r, input logic [NB-1:0] a1, a2, d,
                                           input logic m, b);
    logic l, f;
    l = hz(a1, a2, d, m);
    f = b && !l;
    if (r) return 8'h00;
    case (m_mode)
      M_RUN, M_STEP: return {!l, !l, f, l, 1'b1, 1'b0, 2'(m_mode)};
      M_DRAIN:       return {f, !l, !l, l, 1'b1, 1'b0, 2'(m_mode)};
      default:       return {5'b0, 1'b1, 2'(m_mode)};
    endcase
  endfunction

  task automatic model_step(input logic r, input logic [NB-1:0] a1, a2, d,
                            input logic m, b, h, s, rs);
    logic l;
    l = hz(a1, a2, d, m);
`ifdef PIPELINE_CTRL_PERF_EN
    if (r) begin
      m_stall = 0;
      m_flush = 0;
    end else begin
      if (l && (m_mode == M_RUN || m_mode == M_STEP) && m_stall < 64'hFFFFFFFF) m_stall++;
      if (b && !l && m_flush < 64'hFFFFFFFF) m_flush++;
    end
`endif
    if (r) begin
      m_mode       = M_RUN;
      m_drain_left = 0;
    end else begin
      case (m_mode)
        M_RUN: if (h) begin m_mode = M_DRAIN; m_drain_left = DRN; end
        M_DRAIN: if (!l) begin
          m_drain_left--;
          if (m_drain_left == 0) m_mode = M_HALT;
        end
        M_HALT: if (rs) m_mode = M_RUN; else if (s) m_mode = M_STEP;
        default: m_mode = M_HALT;
      endcase
    end
  endtask

  // One clock: drive on the falling edge, compare 1 ns later, advance the model on the rising edge.
  task automatic cycle(input logic r, input logic [NB-1:0] a1, a2, d,
                       input logic m, b, h, s, rs, input string name);
    @(negedge clk);
    rst = r; rs1 = a1; rs2 = a2; rd = d; mr = m; br = b; halt = h; stp = s; res = rs;
    #1;
    act_v = {pc_en, if_id_en, if_id_flush, id_ex_flush, pipe_en, halted, state};
    check(name, 32'(act_v), 32'(model_out(r, a1, a2, d, m, b)));
    @(posedge clk);
    model_step(r, a1, a2, d, m, b, h, s, rs);
  endtask

  task automatic idle(input logic h, s, rs, input string name);
    cycle(1'b0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, h, s, rs, name);
  endtask

  typedef struct {
    logic [NB-1:0] rs1, rs2, rd;
    logic          mr, br;
    logic [7:0]    exp;
  } vec_t;

  vec_t tbl[8];

  initial begin
    rst = 1'b1; rs1 = '0; rs2 = '0; rd = '0; mr = 1'b0; br = 1'b0;
    halt = 1'b0; stp = 1'b0; res = 1'b0;

    tbl[0] = '{5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 8'b00011_0_00}; // lw rd=5, rs1=5: stall
    tbl[1] = '{5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 8'b11001_0_00}; // no dependency
    tbl[2] = '{5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 8'b11001_0_00}; // x0 never stalls
    tbl[3] = '{5'd3, 5'd7, 5'd7, 1'b1, 1'b0, 8'b00011_0_00}; // rs2 match
    tbl[4] = '{5'd5, 5'd5, 5'd5, 1'b0, 1'b0, 8'b11001_0_00}; // not a load
    tbl[5] = '{5'd1, 5'd3, 5'd2, 1'b1, 1'b1, 8'b11101_0_00}; // taken branch, no lu
    tbl[6] = '{5'd4, 5'd3, 5'd4, 1'b1, 1'b1, 8'b00011_0_00}; // taken branch under lu
    tbl[7] = '{5'd9, 5'd9, 5'd9, 1'b0, 1'b1, 8'b11101_0_00}; // taken branch, no load

    // Reset holds every output low, even with a halt request pending.
    for (int i = 0; i < 3; i++) cycle(1'b1, 5'd5, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, "reset");
    check("reset_outputs", 32'(act_v), 32'h0);

    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, tbl[i].rs1, tbl[i].rs2, tbl[i].rd, tbl[i].mr, tbl[i].br, 1'b0, 1'b0, 1'b0, "table_model");
      check($sformatf("table_%0d", i), 32'(act_v), 32'(tbl[i].exp));
    end

    // A single load-use stall releases on the following cycle.
    cycle(1'b0, 5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "lu_stall");
    check("lu_stall", 32'(act_v[7:3]), 32'b00011);
    idle(1'b0, 1'b0, 1'b0, "lu_release");
    check("lu_release", 32'(act_v[7:3]), 32'b11001);

    // Plain halt: DRAIN_CYCLES flushing drain cycles, then halted.
    idle(1'b1, 1'b0, 1'b0, "halt_req");
    check("halt_req_state", 32'(act_v[1:0]), 32'd0);
    for (int i = 0; i < DRN; i++) begin
      idle(1'b1, 1'b0, 1'b0, "drain");
      check("drain_state", 32'(act_v[1:0]), 32'd1);
      check("drain_flush", 32'(act_v[5]), 32'd1);
    end
    idle(1'b1, 1'b0, 1'b0, "halted");
    check("halted", 32'(act_v), 32'b00000_1_10);

    // Resume, then halt with a load-use on the second drain cycle: drain lasts one cycle longer.
    idle(1'b0, 1'b0, 1'b1, "resume");
    idle(1'b1, 1'b0, 1'b0, "halt_req2");
    check("halt_req2_state", 32'(act_v[1:0]), 32'd0);
    for (int i = 0; i < DRN + 1; i++) begin
      if (i == 1) begin
        cycle(1'b0, 5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "drain_lu");
        check("drain_lu_outs", 32'(act_v[7:3]), 32'b00011);
      end else begin
        idle(1'b1, 1'b0, 1'b0, "drain_ext");
      end
      check("drain_ext_state", 32'(act_v[1:0]), 32'd1);
    end
    idle(1'b0, 1'b0, 1'b0, "halted2");
    check("halted2_state", 32'(act_v[1:0]), 32'd2);

    // Single step: exactly one STEP cycle behaving like RUN.
    idle(1'b0, 1'b1, 1'b0, "step_req");
    idle(1'b1, 1'b1, 1'b1, "step_cycle");
    check("step_cycle", 32'(act_v), 32'b11001_0_11);
    idle(1'b0, 1'b0, 1'b0, "step_back");
    check("step_back_state", 32'(act_v[1:0]), 32'd2);

    // Step and resume together: resume wins.
    idle(1'b0, 1'b1, 1'b1, "step_resume");
    idle(1'b0, 1'b0, 1'b0, "after_step_resume");
    check("step_resume_state", 32'(act_v[1:0]), 32'd0);

    // Reset during the second drain cycle leaves no residual drain.
    idle(1'b1, 1'b0, 1'b0, "rst_halt");
    idle(1'b1, 1'b0, 1'b0, "rst_drain1");
    cycle(1'b1, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "rst_drain2");
    check("rst_mid_drain", 32'(act_v), 32'h0);
    cycle(1'b1, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "rst_hold");
    idle(1'b0, 1'b0, 1'b0, "rst_release");
    check("rst_release", 32'(act_v), 32'b11001_0_00);
    idle(1'b0, 1'b0, 1'b0, "rst_release2");
    check("rst_release2", 32'(act_v[1:0]), 32'd0);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 4000; i++) begin
      cycle(($urandom_range(0, 199) == 0),
            NB'($urandom_range(0, 3)), NB'($urandom_range(0, 3)), NB'($urandom_range(0, 3)),
            ($urandom_range(0, 1) == 1), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 5) == 0), "random");
    end

`ifdef PIPELINE_CTRL_PERF_EN
    #1;
    check("stall_cnt", stall_cnt, 32'(m_stall));
    check("flush_cnt", flush_cnt, 32'(m_flush));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

`ifdef PIPELINE_CTRL_PERF_EN
  initial begin
    m_stall = 0;
    m_flush = 0;
  end
`endif

endmodule
